// File: rtl/daq_apb_sequencer.sv
// daq_apb_sequencer: APB master that writes an acquisition command to the DAQ slave,
// polls its STATUS register until it is no longer busy, then reads back the RESULT.
module daq_apb_sequencer #(
    parameter logic [7:0]  ADDR_CMD    = 8'h00,
    parameter logic [7:0]  ADDR_STATUS = 8'h04,
    parameter logic [7:0]  ADDR_RESULT = 8'h08,
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned MAX_POLLS   = 256
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        res_tout,
    output logic        seq_busy,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [7:0]  M_PADDR,
    output logic [31:0] M_PWDATA,
    input  logic [31:0] M_PRDATA,
    input  logic        M_PREADY,
    input  logic        M_PSLVERR
);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_ACCESS, P_WAIT, P_SETUP, P_ACCESS, R_SETUP, R_ACCESS, RESP
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [PW-1:0] polls_q, polls_d;
    logic [31:0]   data_d;
    logic          err_d, tout_d;

    // Result fields are built up here and only become visible once the FSM reaches RESP.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        polls_d = polls_q;
        data_d  = res_data;
        err_d   = res_err;
        tout_d  = res_tout;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = W_SETUP;
                polls_d = '0;
            end
            W_SETUP: state_d = W_ACCESS;
            W_ACCESS: if (M_PREADY) begin
                state_d = M_PSLVERR ? RESP : P_WAIT;
                gap_d   = GW'(POLL_GAP - 1);
                err_d   = M_PSLVERR;
            end
            P_WAIT: begin
                state_d = gap_q == '0 ? P_SETUP : P_WAIT;
                gap_d   = gap_q - 1'b1;
            end
            P_SETUP: state_d = P_ACCESS;
            P_ACCESS: if (M_PREADY) begin
                polls_d = polls_q == PW'(MAX_POLLS) ? polls_q : polls_q + 1'b1;
                gap_d   = GW'(POLL_GAP - 1);
                if (M_PSLVERR) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (M_PRDATA[2]) begin
                    state_d = polls_d == PW'(MAX_POLLS) ? RESP : P_WAIT;
                    tout_d  = polls_d == PW'(MAX_POLLS);
                end else if (M_PRDATA[1:0] == 2'b01) begin
                    state_d = R_SETUP;
                end else begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    data_d  = M_PRDATA;
                end
            end
            R_SETUP: state_d = R_ACCESS;
            R_ACCESS: if (M_PREADY) begin
                state_d = RESP;
                err_d   = M_PSLVERR;
                data_d  = M_PSLVERR ? '0 : M_PRDATA;
            end
            RESP: if (res_ready) begin
                state_d = IDLE;
                data_d  = '0;
                err_d   = 1'b0;
                tout_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and handshake outputs are registered from the next state so they change with it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            polls_q   <= '0;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            res_tout  <= 1'b0;
            seq_busy  <= 1'b0;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PWRITE  <= 1'b0;
            M_PADDR   <= '0;
            M_PWDATA  <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            polls_q   <= polls_d;
            cmd_ready <= state_d == IDLE;
            res_valid <= state_d == RESP;
            seq_busy  <= state_d != IDLE;
            res_data  <= data_d;
            res_err   <= err_d;
            res_tout  <= tout_d;
            M_PSEL    <= state_d inside {W_SETUP, W_ACCESS, P_SETUP, P_ACCESS, R_SETUP, R_ACCESS};
            M_PENABLE <= state_d inside {W_ACCESS, P_ACCESS, R_ACCESS};
            M_PWRITE  <= state_d inside {W_SETUP, W_ACCESS};
            M_PADDR   <= state_d inside {W_SETUP, W_ACCESS} ? ADDR_CMD :
                         state_d inside {P_SETUP, P_ACCESS} ? ADDR_STATUS :
                         state_d inside {R_SETUP, R_ACCESS} ? ADDR_RESULT : M_PADDR;
            if (state_q == IDLE && cmd_valid)
                M_PWDATA <= cmd_data;
        end
    end
endmodule

// File: tb/tb_daq_apb_sequencer.sv
// tb_daq_apb_sequencer: drives commands into the sequencer against a scripted APB slave
// and compares each result, poll count and latency with a transaction-level model.
module tb_daq_apb_sequencer;
    localparam int G    = 2;
    localparam int MAXP = 4;
    localparam logic [7:0] A_CMD = 8'h00, A_ST = 8'h04, A_RES = 8'h08;

    logic        PCLK = 1'b0, PRESETn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, res_valid, res_ready = 1'b0;
    logic [31:0] cmd_data = '0, res_data;
    logic        res_err, res_tout, seq_busy;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [7:0]  M_PADDR;
    logic [31:0] M_PWDATA, M_PRDATA = '0;
    logic        M_PREADY = 1'b0, M_PSLVERR = 1'b0;

    daq_apb_sequencer #(.ADDR_CMD(A_CMD), .ADDR_STATUS(A_ST), .ADDR_RESULT(A_RES),
                        .POLL_GAP(G), .MAX_POLLS(MAXP)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .res_tout(res_tout), .seq_busy(seq_busy),
        .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE), .M_PADDR(M_PADDR),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          nbusy;
        logic [31:0] fstat, result, cmd;
        int          ws;
        bit          err_en;
        logic [7:0]  err_addr;
        int          hold;
        logic [31:0] edata;
        bit          eerr, etout;
        int          epolls, ereads;
    } vec_t;

    int tests = 0, fails = 0;

    int          nbusy = 0, ws = 0;
    logic [31:0] fstat = 32'h1, result = '0, busy_word = 32'h4;
    bit          err_en = 1'b0;
    logic [7:0]  err_addr = 8'hFF;

    int          n_cmd = 0, n_stat = 0, n_res = 0, gap_bad = 0, rgap_bad = 0, stab_bad = 0;
    int          served = 0, idle = 0, wcnt = 0;
    bit          held = 1'b0;
    logic [31:0] last_cmd = '0, h_wdata = '0;
    logic [7:0]  h_addr = '0;
    logic        h_wr = 1'b0;

    // Scripted slave: STATUS reports busy for nbusy reads, then fstat; ws wait states per access.
    always @(negedge PCLK) begin
        if (held && !(M_PSEL && M_PENABLE && M_PADDR == h_addr && M_PWDATA == h_wdata && M_PWRITE == h_wr))
            stab_bad++;
        if (M_PSEL && !M_PENABLE && M_PADDR == A_ST && idle != G) gap_bad++;
        if (M_PSEL && !M_PENABLE && M_PADDR == A_RES && idle != 0) rgap_bad++;
        idle = M_PSEL ? 0 : idle + 1;
        if (M_PSEL && M_PENABLE) begin
            M_PREADY = wcnt >= ws;
            wcnt++;
            held = !M_PREADY;
            h_addr = M_PADDR;
            h_wdata = M_PWDATA;
            h_wr = M_PWRITE;
            M_PSLVERR = M_PREADY && err_en && M_PADDR == err_addr;
            M_PRDATA = !M_PREADY ? $urandom :
                       M_PADDR == A_ST ? (served < nbusy ? busy_word : fstat) :
                       M_PADDR == A_RES ? result : 32'h0;
            if (M_PREADY && M_PWRITE) begin
                n_cmd++;
                last_cmd = M_PWDATA;
                served = 0;
            end else if (M_PREADY && M_PADDR == A_ST) begin
                n_stat++;
                served++;
            end else if (M_PREADY && M_PADDR == A_RES) n_res++;
        end else begin
            M_PREADY = 1'b0;
            M_PSLVERR = 1'b0;
            wcnt = 0;
            held = 1'b0;
            M_PRDATA = $urandom;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int nb, logic [31:0] fs, logic [31:0] res, logic [31:0] cmd, int w,
                                bit ee, logic [7:0] ea, int hold, logic [31:0] ed, bit er, bit to,
                                int np, int nr);
        vec_t v;
        v.nbusy = nb; v.fstat = fs; v.result = res; v.cmd = cmd; v.ws = w;
        v.err_en = ee; v.err_addr = ea; v.hold = hold;
        v.edata = ed; v.eerr = er; v.etout = to; v.epolls = np; v.ereads = nr;
        return v;
    endfunction

    // Transaction-level view: how many polls happen and what the outcome is.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.epolls = 0; r.ereads = 0; r.edata = '0; r.eerr = 1'b0; r.etout = 1'b0;
        if (v.err_en && v.err_addr == A_CMD) r.eerr = 1'b1;
        else if (v.err_en && v.err_addr == A_ST) begin
            r.epolls = 1; r.eerr = 1'b1;
        end else if (v.nbusy >= MAXP) begin
            r.epolls = MAXP; r.etout = 1'b1;
        end else begin
            r.epolls = v.nbusy + 1;
            if (v.fstat[1:0] == 2'b01) begin
                r.ereads = 1;
                r.eerr = v.err_en;
                r.edata = v.err_en ? 32'h0 : v.result;
            end else begin
                r.eerr = 1'b1;
                r.edata = v.fstat;
            end
        end
        return r;
    endfunction

    // Cycle index (1 = first cycle after the accept edge) at which res_valid is first high.
    function automatic int lat(input vec_t v);
        return (2 + v.ws) + v.epolls * (G + 2 + v.ws) + v.ereads * (2 + v.ws) + 1;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int c0, s0, r0, b0, cyc;
        nbusy = v.nbusy; fstat = v.fstat; result = v.result; ws = v.ws;
        err_en = v.err_en; err_addr = v.err_addr; busy_word = $urandom | 32'h4;
        c0 = n_cmd; s0 = n_stat; r0 = n_res; b0 = gap_bad + rgap_bad + stab_bad;
        chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_data = v.cmd;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = v.hold > 0;
        cmd_data = ~v.cmd;
        cyc = 1;
        while (!res_valid && cyc < 400) begin
            @(negedge PCLK);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat(v)));
        chk({tag, " res_data"}, res_data, v.edata);
        chk({tag, " err_tout"}, 32'({res_err, res_tout}), 32'({v.eerr, v.etout}));
        chk({tag, " busy_ready"}, 32'({seq_busy, cmd_ready}), 32'(2'b10));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge PCLK);
            chk({tag, " hold_flags"}, 32'({res_valid, cmd_ready, res_err, res_tout}),
                32'({1'b1, 1'b0, v.eerr, v.etout}));
            chk({tag, " hold_data"}, res_data, v.edata);
        end
        res_ready = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({tag, " after_hs"}, 32'({res_valid, cmd_ready, seq_busy}), 32'(3'b010));
        chk({tag, " cmd_writes"}, 32'(n_cmd - c0), 32'd1);
        chk({tag, " cmd_word"}, last_cmd, v.cmd);
        chk({tag, " status_reads"}, 32'(n_stat - s0), 32'(v.epolls));
        chk({tag, " result_reads"}, 32'(n_res - r0), 32'(v.ereads));
        chk({tag, " gap_stability"}, 32'(gap_bad + rgap_bad + stab_bad - b0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        int   r, k;
        tbl[0]  = mk(0, 32'h1, 32'hFAB, 32'h9000_0000, 0, 0, 8'hFF, 0, 32'hFAB, 0, 0, 1, 1);
        tbl[1]  = mk(3, 32'h1, 32'h1234, 32'h0000_00C3, 0, 0, 8'hFF, 0, 32'h1234, 0, 0, 4, 1);
        tbl[2]  = mk(10, 32'h1, 32'h5555, 32'h11, 0, 0, 8'hFF, 0, 32'h0, 0, 1, 4, 0);
        tbl[3]  = mk(0, 32'h2, 32'h7777, 32'h22, 0, 0, 8'hFF, 0, 32'h2, 1, 0, 1, 0);
        tbl[4]  = mk(0, 32'h1, 32'h7777, 32'h33, 0, 1, A_CMD, 0, 32'h0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 32'h1, 32'hCAFE, 32'hDEAD_0001, 3, 0, 8'hFF, 5, 32'hCAFE, 0, 0, 2, 1);
        tbl[6]  = mk(0, 32'hA5A5_0000, 32'h1, 32'h44, 0, 0, 8'hFF, 0, 32'hA5A5_0000, 1, 0, 1, 0);
        tbl[7]  = mk(2, 32'h3, 32'h1, 32'h55, 1, 0, 8'hFF, 0, 32'h3, 1, 0, 3, 0);
        tbl[8]  = mk(0, 32'h1, 32'h9, 32'h66, 0, 1, A_ST, 0, 32'h0, 1, 0, 1, 0);
        tbl[9]  = mk(0, 32'h1, 32'h9, 32'h77, 2, 1, A_RES, 0, 32'h0, 1, 0, 1, 1);
        tbl[10] = mk(4, 32'h1, 32'h9, 32'h88, 0, 0, 8'hFF, 2, 32'h0, 0, 1, 4, 0);
        tbl[11] = mk(3, 32'h8000_0001, 32'h0BAD_F00D, 32'h99, 1, 0, 8'hFF, 0, 32'h0BAD_F00D, 0, 0, 4, 1);

        #1 PRESETn = 1'b0;
        #1 chk("rst_async_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge PCLK);
        chk("rst_flags", 32'({cmd_ready, res_valid, res_err, res_tout, seq_busy, M_PSEL, M_PENABLE, M_PWRITE}),
            32'(8'b1000_0000));
        chk("rst_data", res_data | M_PWDATA | 32'(M_PADDR), 32'h0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset pulse in the middle of a STATUS access.
        nbusy = 10; ws = 0; err_en = 1'b0; busy_word = 32'h4;
        cmd_valid = 1'b1;
        cmd_data = 32'h0606_0606;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        k = 0;
        while (!(M_PSEL && M_PENABLE && M_PADDR == A_ST) && k < 50) begin
            @(negedge PCLK);
            k++;
        end
        chk("t6_reach_poll", 32'(k < 50), 32'd1);
        #1 PRESETn = 1'b0;
        #1 chk("t6_async_drop", 32'({M_PSEL, M_PENABLE, cmd_ready, seq_busy, res_valid}), 32'(5'b00100));
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("t6_idle_after", 32'({M_PSEL, cmd_ready, seq_busy}), 32'(3'b010));
        run_vec(tbl[0], "t6_next");

        for (int i = 0; i < 30; i++) begin
            v.nbusy = $urandom_range(0, 5);
            v.fstat = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 2) == 0 ? $urandom_range(0, 3) : 1);
            v.result = $urandom;
            v.cmd = $urandom;
            v.ws = $urandom_range(0, 2);
            r = $urandom_range(0, 7);
            v.err_en = r < 3;
            v.err_addr = r == 0 ? A_CMD : r == 1 ? A_ST : A_RES;
            v.hold = $urandom_range(0, 2);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
